// File: rtl/station_scheduler_if.sv
// Bundle of decode, station-array and issue-port signals around the
// station scheduler. The scheduler side uses the master modport; the
// decode/station/execute environment uses the slave modport.
interface station_scheduler_if #(
    parameter int NS = 4
);
    localparam int SW = $clog2(NS);

    // decode side
    logic              id_valid;
    logic              id_stall;
    logic [NS-1:0]     st_feed;

    // station array status and pending-uOp fields
    logic [NS-1:0]     st_complete;
    logic [NS-1:0]     st_ready;
    logic [NS*3-1:0]   st_a_adr;
    logic [NS*3-1:0]   st_b_adr;
    logic [NS*4-1:0]   st_d_adr;
    logic [NS-1:0]     st_ld_mem;
    logic [NS-1:0]     st_st_mem;
    logic [NS-1:0]     st_lock_loads;
    logic [NS*4-1:0]   st_lock_reg_wr;
    logic [NS*3-1:0]   st_lock_reg_rd_0;
    logic [NS*3-1:0]   st_lock_reg_rd_1;
    logic [NS*3-1:0]   st_lock_reg_rd_2;
    logic [NS-1:0]     st_ack;

    // execute side
    logic              iss_ready;
    logic              iss_valid;
    logic [SW-1:0]     iss_sel;

    modport master (
        input  id_valid,
        output id_stall,
        output st_feed,
        input  st_complete,
        input  st_ready,
        input  st_a_adr,
        input  st_b_adr,
        input  st_d_adr,
        input  st_ld_mem,
        input  st_st_mem,
        input  st_lock_loads,
        input  st_lock_reg_wr,
        input  st_lock_reg_rd_0,
        input  st_lock_reg_rd_1,
        input  st_lock_reg_rd_2,
        output st_ack,
        input  iss_ready,
        output iss_valid,
        output iss_sel
    );

    modport slave (
        output id_valid,
        input  id_stall,
        input  st_feed,
        output st_complete,
        output st_ready,
        output st_a_adr,
        output st_b_adr,
        output st_d_adr,
        output st_ld_mem,
        output st_st_mem,
        output st_lock_loads,
        output st_lock_reg_wr,
        output st_lock_reg_rd_0,
        output st_lock_reg_rd_1,
        output st_lock_reg_rd_2,
        input  st_ack,
        output iss_ready,
        input  iss_valid,
        input  iss_sel
    );
endinterface

// File: rtl/station_scheduler.sv
// In-order-allocate, out-of-order-issue scheduler for a ring of NS
// reservation stations. Owns head/tail/count of the ring, feeds decoded
// uOps into the tail station, retires from the head, and each cycle picks
// the oldest hazard-free ready station for the shared execute datapath.
// The issue path is combinational: execute registers the station fields
// through iss_sel on the same edge that the station consumes st_ack.
module station_scheduler #(
    parameter int NS = 4
) (
    input  logic               clk,
    input  logic               a_rst,
    station_scheduler_if.master bus
);
    localparam int SW = $clog2(NS);

    localparam logic [SW-1:0] PTR_ZERO  = {SW{1'b0}};
    localparam logic [SW-1:0] PTR_ONE   = SW'(1);
    localparam logic [SW:0]   CNT_ZERO  = {(SW+1){1'b0}};
    localparam logic [SW:0]   CNT_ONE   = (SW+1)'(1);
    localparam logic [SW:0]   CNT_FULL  = (SW+1)'(NS);
    localparam logic [NS-1:0] VEC_ZERO  = {NS{1'b0}};
    localparam logic [NS-1:0] ONE_HOT_0 = NS'(1);

    // True when an older active slot (j fields) must hold back candidate k.
    function automatic logic hazard(
        input logic [3:0] wr_lock_j,
        input logic [2:0] rd0_j,
        input logic [2:0] rd1_j,
        input logic [2:0] rd2_j,
        input logic       lock_loads_j,
        input logic [2:0] a_k,
        input logic [2:0] b_k,
        input logic [3:0] d_k,
        input logic       ld_k
    );
        logic raw;
        logic war;
        logic waw;
        logic mem;
        raw = wr_lock_j[3] & ((wr_lock_j[2:0] == a_k) | (wr_lock_j[2:0] == b_k));
        war = d_k[3] & ((d_k[2:0] == rd0_j) | (d_k[2:0] == rd1_j) | (d_k[2:0] == rd2_j));
        waw = d_k[3] & wr_lock_j[3] & (d_k[2:0] == wr_lock_j[2:0]);
        mem = ld_k & lock_loads_j;
        return raw | war | waw | mem;
    endfunction

    // ring registers
    logic [SW-1:0] head_r;
    logic [SW-1:0] tail_r;
    logic [SW:0]   count_r;

    // per-slot unpacked station fields
    logic [2:0] a_adr_s   [NS];
    logic [2:0] b_adr_s   [NS];
    logic [3:0] d_adr_s   [NS];
    logic [3:0] lock_wr_s [NS];
    logic [2:0] lock_rd0_s[NS];
    logic [2:0] lock_rd1_s[NS];
    logic [2:0] lock_rd2_s[NS];

    // per-slot status
    logic [SW-1:0] age_s[NS];
    logic [NS-1:0] occ_s;
    logic [NS-1:0] active_s;
    logic [NS-1:0] cand_s;
    logic [NS-1:0] blocked_s;
    logic [NS-1:0] eligible_s;

    // control
    logic          full_s;
    logic          feed_s;
    logic          retire_s;
    logic          found_s;
    logic [SW-1:0] pick_s;
    logic          issue_s;

    // Allocation and retire decisions; nothing is fed while reset is held.
    always_comb begin
        full_s   = (count_r == CNT_FULL);
        feed_s   = bus.id_valid & ~full_s & ~a_rst;
        retire_s = (count_r != CNT_ZERO) & bus.st_complete[head_r];
    end

    // Split the flat station buses into per-slot fields.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            a_adr_s[s]    = bus.st_a_adr[s*3 +: 3];
            b_adr_s[s]    = bus.st_b_adr[s*3 +: 3];
            d_adr_s[s]    = bus.st_d_adr[s*4 +: 4];
            lock_wr_s[s]  = bus.st_lock_reg_wr[s*4 +: 4];
            lock_rd0_s[s] = bus.st_lock_reg_rd_0[s*3 +: 3];
            lock_rd1_s[s] = bus.st_lock_reg_rd_1[s*3 +: 3];
            lock_rd2_s[s] = bus.st_lock_reg_rd_2[s*3 +: 3];
        end
    end

    // Age relative to head (modulo NS), occupancy, active and candidate flags.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            age_s[s]    = SW'(s) - head_r;
            occ_s[s]    = ({1'b0, age_s[s]} < count_r);
            active_s[s] = occ_s[s] & ~bus.st_complete[s];
            cand_s[s]   = occ_s[s] & bus.st_ready[s];
        end
    end

    // A candidate is blocked by any hazard against an older active slot.
    always_comb begin
        blocked_s = VEC_ZERO;
        for (int k = 0; k < NS; k++) begin
            for (int j = 0; j < NS; j++) begin
                blocked_s[k] = blocked_s[k]
                    | (active_s[j] & (age_s[j] < age_s[k])
                       & hazard(lock_wr_s[j], lock_rd0_s[j], lock_rd1_s[j],
                                lock_rd2_s[j], bus.st_lock_loads[j],
                                a_adr_s[k], b_adr_s[k], d_adr_s[k],
                                bus.st_ld_mem[k]));
            end
        end
    end

    // Stores may only leave from the head slot.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            eligible_s[k] = cand_s[k] & ~blocked_s[k]
                          & (~bus.st_st_mem[k] | (SW'(k) == head_r));
        end
    end

    // Walk slots from head in age order and keep the first eligible one.
    always_comb begin : select_oldest
        logic [SW-1:0] idx;
        idx     = PTR_ZERO;
        found_s = 1'b0;
        pick_s  = PTR_ZERO;
        for (int a = 0; a < NS; a++) begin
            idx = head_r + SW'(a);
            if (!found_s && eligible_s[idx]) begin
                found_s = 1'b1;
                pick_s  = idx;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Drive feed, stall, ack and issue-port outputs.
    always_comb begin
        issue_s       = found_s & bus.iss_ready & ~a_rst;
        bus.id_stall  = full_s;
        bus.iss_valid = issue_s;
        if (feed_s) begin
            bus.st_feed = ONE_HOT_0 << tail_r;
        end else begin
            bus.st_feed = VEC_ZERO;
        end
        if (issue_s) begin
            bus.st_ack  = ONE_HOT_0 << pick_s;
            bus.iss_sel = pick_s;
        end else begin
            bus.st_ack  = VEC_ZERO;
            bus.iss_sel = PTR_ZERO;
        end
    end

    // Ring pointer and occupancy registers.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (feed_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (retire_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({feed_s, retire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_station_scheduler.sv
// Bench for station_scheduler: directed scenarios with literal expectations
// plus a long randomized run, all compared every cycle against a queue-based
// model of ring occupancy and hazard rules.
module tb_station_scheduler;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic a_rst;
    always #5 clk = ~clk;

    station_scheduler_if #(.NS(NS)) bus();
    station_scheduler #(.NS(NS)) dut (.clk(clk), .a_rst(a_rst), .bus(bus));

    // stimulus state
    logic       id_valid;
    logic       iss_ready;
    logic       cmpl[NS];
    logic       rdy[NS];
    logic       ld[NS];
    logic       stm[NS];
    logic       lkl[NS];
    logic [2:0] aa[NS];
    logic [2:0] ba[NS];
    logic [2:0] r0[NS];
    logic [2:0] r1[NS];
    logic [2:0] r2[NS];
    logic [3:0] da[NS];
    logic [3:0] lw[NS];

    // pack stimulus onto the interface
    always_comb begin
        bus.id_valid  = id_valid;
        bus.iss_ready = iss_ready;
        for (int k = 0; k < NS; k++) begin
            bus.st_complete[k]          = cmpl[k];
            bus.st_ready[k]             = rdy[k];
            bus.st_ld_mem[k]            = ld[k];
            bus.st_st_mem[k]            = stm[k];
            bus.st_lock_loads[k]        = lkl[k];
            bus.st_a_adr[k*3 +: 3]      = aa[k];
            bus.st_b_adr[k*3 +: 3]      = ba[k];
            bus.st_d_adr[k*4 +: 4]      = da[k];
            bus.st_lock_reg_wr[k*4 +: 4] = lw[k];
            bus.st_lock_reg_rd_0[k*3 +: 3] = r0[k];
            bus.st_lock_reg_rd_1[k*3 +: 3] = r1[k];
            bus.st_lock_reg_rd_2[k*3 +: 3] = r2[k];
        end
    end

    // model: queue of occupied slot indices, oldest first
    int mq[$];
    int mtail;
    logic [31:0] exp_stall, exp_feed, exp_ack, exp_valid, exp_sel;
    bit m_feed, m_retire;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit blocks(int j, int k);
        bit raw, war, waw, mem;
        raw = lw[j][3] && (lw[j][2:0] == aa[k] || lw[j][2:0] == ba[k]);
        war = da[k][3] && (da[k][2:0] == r0[j] || da[k][2:0] == r1[j] || da[k][2:0] == r2[j]);
        waw = da[k][3] && lw[j][3] && (da[k][2:0] == lw[j][2:0]);
        mem = ld[k] && lkl[j];
        return raw || war || waw || mem;
    endfunction

    task automatic model_eval();
        int pick;
        pick      = -1;
        exp_stall = (mq.size() == NS) ? 32'd1 : 32'd0;
        m_feed    = id_valid && (mq.size() != NS) && !a_rst;
        m_retire  = !a_rst && (mq.size() > 0) && cmpl[mq[0]];
        for (int p = 0; p < mq.size(); p++) begin
            int k;
            bit ok;
            k = mq[p];
            if (pick >= 0 || !rdy[k]) continue;
            ok = !(stm[k] && p != 0);
            for (int q = 0; q < p; q++)
                if (!cmpl[mq[q]] && blocks(mq[q], k)) ok = 0;
            if (ok) pick = k;
        end
        exp_valid = (pick >= 0 && iss_ready && !a_rst) ? 32'd1 : 32'd0;
        exp_sel   = exp_valid[0] ? pick : 0;
        exp_ack   = exp_valid[0] ? (32'd1 << pick) : 32'd0;
        exp_feed  = m_feed ? (32'd1 << mtail) : 32'd0;
    endtask

    task automatic check_now();
        #1;
        model_eval();
        chk("id_stall",  bus.id_stall,  exp_stall);
        chk("st_feed",   bus.st_feed,   exp_feed);
        chk("st_ack",    bus.st_ack,    exp_ack);
        chk("iss_valid", bus.iss_valid, exp_valid);
        chk("iss_sel",   bus.iss_sel,   exp_sel);
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_retire) void'(mq.pop_front());
        if (m_feed) begin
            mq.push_back(mtail);
            mtail = (mtail + 1) % NS;
        end
        @(negedge clk);
    endtask

    task automatic step();
        check_now();
        tick();
    endtask

    task automatic model_clear();
        mq.delete();
        mtail = 0;
    endtask

    task automatic idle_inputs();
        id_valid  = 1'b0;
        iss_ready = 1'b1;
        for (int k = 0; k < NS; k++) begin
            cmpl[k] = 1'b1; rdy[k] = 1'b0; ld[k] = 1'b0; stm[k] = 1'b0; lkl[k] = 1'b0;
            aa[k] = 3'd0; ba[k] = 3'd0; r0[k] = 3'd0; r1[k] = 3'd0; r2[k] = 3'd0;
            da[k] = 4'd0; lw[k] = 4'd0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        a_rst = 1'b1;
        model_clear();
        @(negedge clk);
        check_now();
        a_rst = 1'b0;
    endtask

    task automatic feed_n(input int n);
        for (int k = 0; k < NS; k++) cmpl[k] = 1'b0;
        id_valid = 1'b1;
        for (int i = 0; i < n; i++) step();
        id_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        a_rst = 1'b1;
        model_clear();
        #12;
        // reset state
        do_reset();
        chk("rst_stall", bus.id_stall, 32'd0);
        chk("rst_ack",   bus.st_ack,   32'd0);
        chk("rst_valid", bus.iss_valid, 32'd0);
        chk("rst_sel",   bus.iss_sel,  32'd0);
        chk("rst_feed",  bus.st_feed,  32'd0);

        // fill and stall
        for (int k = 0; k < NS; k++) cmpl[k] = 1'b0;
        id_valid = 1'b1;
        for (int i = 0; i < NS; i++) begin
            check_now();
            chk("fill_feed",  bus.st_feed,  32'd1 << i);
            chk("fill_stall", bus.id_stall, 32'd0);
            tick();
        end
        check_now();
        chk("full_stall", bus.id_stall, 32'd1);
        chk("full_feed",  bus.st_feed,  32'd0);
        tick();

        // out-of-order issue past a non-ready writer
        id_valid = 1'b0;
        lw[0] = 4'b1011;
        rdy[1] = 1'b1; aa[1] = 3'd2; ba[1] = 3'd2;
        check_now();
        chk("ooo_ack", bus.st_ack,  32'b0010);
        chk("ooo_sel", bus.iss_sel, 32'd1);
        tick();
        aa[1] = 3'd3;
        for (int i = 0; i < 2; i++) begin
            check_now();
            chk("raw_ack", bus.st_ack, 32'd0);
            tick();
        end
        cmpl[0] = 1'b1;
        check_now();
        chk("raw_done_ack", bus.st_ack, 32'b0010);
        tick();

        // load / store ordering
        do_reset();
        feed_n(2);
        lkl[0] = 1'b1; rdy[1] = 1'b1; ld[1] = 1'b1;
        check_now();
        chk("ld_lock_ack", bus.st_ack, 32'd0);
        tick();
        lkl[0] = 1'b0; ld[1] = 1'b0; stm[1] = 1'b1;
        check_now();
        chk("st_nohead_ack", bus.st_ack, 32'd0);
        tick();
        cmpl[0] = 1'b1;
        check_now();
        chk("st_retire_ack", bus.st_ack, 32'd0);
        tick();
        check_now();
        chk("st_head_ack", bus.st_ack,  32'b0010);
        chk("st_head_sel", bus.iss_sel, 32'd1);
        tick();

        // back-pressure
        do_reset();
        feed_n(2);
        rdy[0] = 1'b1; rdy[1] = 1'b1; iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_now();
            chk("bp_ack",   bus.st_ack,    32'd0);
            chk("bp_valid", bus.iss_valid, 32'd0);
            tick();
        end
        iss_ready = 1'b1;
        check_now();
        chk("bp_first", bus.st_ack, 32'b0001);
        tick();
        rdy[0] = 1'b0;
        check_now();
        chk("bp_second", bus.st_ack, 32'b0010);
        tick();

        // wrap-around and simultaneous feed/retire
        do_reset();
        feed_n(NS);
        id_valid = 1'b1;
        cmpl[0] = 1'b1; step();
        cmpl[0] = 1'b0; cmpl[1] = 1'b1; step();
        cmpl[1] = 1'b0; cmpl[2] = 1'b1; step();
        cmpl[2] = 1'b0; step();
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        check_now();
        chk("wrap_stall", bus.id_stall, 32'd1);
        chk("wrap_age",   bus.st_ack,   32'b0001);
        tick();
        rdy[0] = 1'b0; rdy[1] = 1'b0; cmpl[3] = 1'b1;
        check_now();
        chk("wrap_nofeed", bus.st_feed, 32'd0);
        tick();
        cmpl[3] = 1'b0;
        check_now();
        chk("wrap_unstall", bus.id_stall, 32'd0);
        chk("wrap_feed",    bus.st_feed,  32'b1000);
        tick();
        id_valid = 1'b0;

        // async reset while acking
        do_reset();
        feed_n(1);
        rdy[0] = 1'b1;
        check_now();
        chk("ar_pre_ack", bus.st_ack, 32'b0001);
        #2;
        a_rst = 1'b1;
        id_valid = 1'b1;
        model_clear();
        #1;
        chk("ar_ack",   bus.st_ack,    32'd0);
        chk("ar_valid", bus.iss_valid, 32'd0);
        chk("ar_feed",  bus.st_feed,   32'd0);
        check_now();
        tick();
        a_rst = 1'b0;
        check_now();
        chk("ar_count0_feed", bus.st_feed, 32'b0001);
        chk("ar_count0_ack",  bus.st_ack,  32'd0);
        tick();

        // randomized run
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            a_rst     = ($urandom_range(0, 199) == 0);
            id_valid  = ($urandom_range(0, 3) != 0);
            iss_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NS; k++) begin
                cmpl[k] = $urandom_range(0, 2) == 0;
                rdy[k]  = $urandom_range(0, 1);
                ld[k]   = $urandom_range(0, 3) == 0;
                stm[k]  = $urandom_range(0, 3) == 0;
                lkl[k]  = $urandom_range(0, 3) == 0;
                aa[k]   = 3'($urandom_range(0, 7));
                ba[k]   = 3'($urandom_range(0, 7));
                r0[k]   = 3'($urandom_range(0, 7));
                r1[k]   = 3'($urandom_range(0, 7));
                r2[k]   = 3'($urandom_range(0, 7));
                da[k]   = 4'($urandom_range(0, 15));
                lw[k]   = 4'($urandom_range(0, 15));
            end
            if (a_rst) model_clear();
            step();
        end
        a_rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/station_scheduler.md
# station_scheduler

In-order-allocate, out-of-order-issue scheduler for a ring of `NS` reservation stations. It owns the allocation pointers that feed decoded uOps into free stations. Each cycle it selects the oldest hazard-free ready station, acknowledges it, and drives the issue-port mux select for the shared ALU/AGU/LSU datapath. It sits between instruction decode, the station array and the execute stage.

## Interface
- `NS`, 4: number of stations; power of two, 2..8. `SW = log2(NS)`.
- `clk` in 1: clock.
- `a_rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: decode presents a uOp.
- `id_stall` out 1: no station can accept this cycle.
- `st_feed` out NS: one-hot feed strobe to the tail station.
- `st_complete` in NS: per-station idle flag.
- `st_ready` in NS: per-station has-uOp-to-issue flag.
- `st_a_adr`, `st_b_adr` in NS*3: source register addresses of the pending uOp.
- `st_d_adr` in NS*4: `[3]` = write enable, `[2:0]` = destination.
- `st_ld_mem`, `st_st_mem` in NS: pending uOp is a load / store.
- `st_lock_loads` in NS: instruction contains a store.
- `st_lock_reg_wr` in NS*4: terminal write lock; `[3]` = valid.
- `st_lock_reg_rd_0/1/2` in NS*3: terminal read locks.
- `st_ack` out NS: one-hot schedule acknowledge.
- `iss_ready` in 1: execute stage accepts a uOp this cycle.
- `iss_valid` out 1: a uOp is issued this cycle.
- `iss_sel` out SW: index of the issued station.

## Operation
- **State.** Registers are `head` (SW), `tail` (SW) and `count` (SW+1, 0..NS). Occupied slots are `head`..`head+count-1` modulo NS. Age of a slot = `(idx - head) mod NS`; lower age is older.
- **Allocation.**
  - `id_stall = (count == NS)`.
  - `st_feed[tail] = id_valid & ~id_stall`.
  - On feed, `tail <= tail+1`, wrapping NS-1 to 0.
- **Retire.** If `count != 0` and `st_complete[head]`, then `head <= head+1`. At most one retire per cycle. A younger station that completes early stays occupied until `head` passes it.
- **Count update.** `count <= count + feed - retire`. Simultaneous feed and retire leaves `count` unchanged.
- **Active.** Slot j is active when it is occupied and `~st_complete[j]`.
- **Candidate.** Slot k is a candidate when it is occupied and `st_ready[k]`.
- **Blocking.** Candidate k is blocked by any active slot j that is older than k if any of the following holds:
  - RAW: `lock_reg_wr[j][3]` and `lock_reg_wr[j][2:0]` equals `a_adr[k]` or `b_adr[k]`.
  - WAR: `d_adr[k][3]` and `d_adr[k][2:0]` equals any of `lock_reg_rd_0/1/2[j]`.
  - WAW: `d_adr[k][3]`, `lock_reg_wr[j][3]`, and the low 3 bits match.
  - Memory: `ld_mem[k]` and `lock_loads[j]`.
- **Store ordering.** A candidate with `st_mem[k]` is eligible only when `k == head`.
- **Selection.** Pick the oldest eligible candidate. If one exists and `iss_ready` is high:
  - `iss_valid = 1`, `iss_sel = k`, `st_ack[k] = 1`.
  - Otherwise all three are 0.
- **Issue path is combinational.** The execute stage registers the station fields through the `iss_sel` mux on the same edge that the station consumes `st_ack`.
- **Newly fed slot.** A slot fed this cycle still shows `st_complete = 1` and `st_ready = 0`, so it is neither a candidate nor a blocker until the next cycle.

## Timing
- **Reset** (async, immediate):
  - `head = tail = 0`, `count = 0`.
  - `id_stall = 0`, `st_feed = 0`, `st_ack = 0`, `iss_valid = 0`, `iss_sel = 0`, since all of these derive from registers and inputs.
- **Reset mid-operation:** pointers clear at once and no `st_ack` or `st_feed` is driven while `a_rst` is high.
- **Feed to issue:** a uOp fed at edge t can issue at the earliest in cycle t+1, provided its station reports ready.
- **Full ring:** a retire in cycle t clears `id_stall` only in cycle t+1; retire is never used to feed in the same cycle.
- **Issue rate:** at most one issue per cycle, with no bubble between back-to-back issues from different or identical stations.
- **Stalled execute:** `iss_ready = 0` forces `st_ack = 0`. Station state holds; no loss and no duplicate ack.
- **Wrap-around:** age comparison is modulo NS. With `head = 3`, `count = 3` and NS = 4, slot 3 is older than slot 0, which is older than slot 1.

## Test plan
- **Fill and stall:** NS = 4, `id_valid` held high with no completions. Required: `st_feed` = 0001, 0010, 0100, 1000 on successive cycles; `id_stall = 1` from the cycle after the 4th feed.
- **Out-of-order issue:** slot 0 writes r3 (lock_wr = 4'b1011) and is not ready; slot 1 reads r2 and is ready. Required: `st_ack = 0010`, `iss_sel = 1`. Then change slot 1 to read r3. Required: no ack until slot 0 completes.
- **Load/store ordering:** slot 0 has `lock_loads = 1` and is active; slot 1 is a ready load. Required: no ack to slot 1. A ready store in slot 1 with `head = 0` gets no ack until `head = 1`.
- **Back-pressure:** two ready, independent slots with `iss_ready` held 0 for 3 cycles. Required: `st_ack = 0` throughout. Then raise `iss_ready`. Required: oldest acked first, the other acked the next cycle.
- **Wrap and simultaneous feed/retire:** `head = 3`, `count = 4`; slot 3 completes while `id_valid = 1`. Required: no feed that cycle; next cycle `head = 0`, `count = 3`, `st_feed = 1000`.
- **Async reset during issue:** assert `a_rst` mid-cycle while `st_ack` is high. Required: `st_ack`, `iss_valid` and `count` go to 0 immediately.
